alu_serial_16: RTL and testbench

ALU_SERIAL_16 -- requirements
Module: alu_serial_16

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_slice_4.sv | 23 ++
 rtl/alu_serial_16.sv | 151 +++++++++++++++
 tb/tb_alu_serial_16.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the nibble-serial ALU
//
// Purpose : state encoding, nibble width and operation select codes shared by
//           alu_serial_16 and alu_slice_4.
// Ports   : none (package).

package alu_pkg;

   // Controller states of the serial ALU.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits processed per clock cycle.
   localparam int NIBBLE = 4;

   // Values of the s input.
   localparam logic OP_ADD = 1'b1;
   localparam logic OP_SUB = 1'b0;

endpackage : alu_pkg

// File: rtl/alu_slice_4.sv
// rtl/alu_slice_4.sv - combinational 4-bit adder with carry-in
//
// Purpose : one nibble of the serial datapath; time-shared across all nibbles
//           of an operation by alu_serial_16.
// Ports   : a, b  - nibble operands (b already inverted for subtract)
//           cin   - carry into bit 0
//           q     - nibble sum
//           cout  - carry out of bit 3

module alu_slice_4
   import alu_pkg::*;
(
   input  logic [NIBBLE-1:0] a,
   input  logic [NIBBLE-1:0] b,
   input  logic              cin,
   output logic [NIBBLE-1:0] q,
   output logic              cout
);

   // Widen by one bit so the carry out falls out of the addition.
   assign {cout, q} = {1'b0, a} + {1'b0, b} + {{NIBBLE{1'b0}}, cin};

endmodule : alu_slice_4

// File: rtl/alu_serial_16.sv
// rtl/alu_serial_16.sv - nibble-serial add/subtract unit with valid/ready handshake
//
// Purpose : accepts a, b and s in IDLE, computes a+b or a-b one nibble per
//           cycle (LSB nibble first) through a single alu_slice_4, then holds
//           the result and flags in DONE until the consumer takes them.
// Ports   : clk, rst_n           - clock, asynchronous active-low reset
//           in_valid, in_ready   - request handshake (in_ready = state IDLE)
//           a, b, s              - operands, s: 1 = add, 0 = subtract
//           out_valid, out_ready - result handshake (out_valid = state DONE)
//           q                    - result modulo 2^WIDTH
//           c                    - carry (add) or borrow (subtract)
//           z                    - result is zero
//           v                    - signed overflow

module alu_serial_16
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic             c,
   output logic             z,
   output logic             v
);

   localparam int NIBBLES = WIDTH / NIBBLE;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int MSB     = WIDTH - 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic              carry;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic              s_r;
   logic [WIDTH-1:0]  q_r;
   logic              c_r;
   logic              z_r;
   logic              v_r;
   logic              in_ready_r;
   logic              out_valid_r;

   logic [WIDTH-1:0]  b_eff;
   logic [IDX_W+1:0]  base;
   logic [NIBBLE-1:0] a_nib;
   logic [NIBBLE-1:0] b_nib;
   logic [NIBBLE-1:0] sum_nib;
   logic              cout;
   logic [WIDTH-1:0]  q_next;

   // Subtract is a + ~b + 1: the +1 comes from the carry register being
   // preloaded with 1 at accept time.
   assign b_eff = (s_r == OP_ADD) ? b_r : ~b_r;

   // Bit offset of the current nibble (idx * 4).
   assign base  = {idx, 2'b00};
   assign a_nib = a_r[base +: NIBBLE];
   assign b_nib = b_eff[base +: NIBBLE];

   alu_slice_4 u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (carry),
      .q    (sum_nib),
      .cout (cout)
   );

   // Result with the current nibble merged in; used both to update q and to
   // derive z/v on the final nibble without an extra cycle.
   always_comb begin
      q_next = q_r;
      q_next[base +: NIBBLE] = sum_nib;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         carry       <= 1'b0;
         a_r         <= '0;
         b_r         <= '0;
         s_r         <= 1'b0;
         q_r         <= '0;
         c_r         <= 1'b0;
         z_r         <= 1'b0;
         v_r         <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r        <= a;
                  b_r        <= b;
                  s_r        <= s;
                  idx        <= '0;
                  carry      <= (s == OP_SUB);
                  state      <= RUN;
                  in_ready_r <= 1'b0;
               end
            end
            RUN: begin
               q_r   <= q_next;
               carry <= cout;
               idx   <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  state       <= DONE;
                  out_valid_r <= 1'b1;
                  idx         <= '0;
                  // For subtract the adder carry is "no borrow", so invert it.
                  c_r         <= (s_r == OP_ADD) ? cout : ~cout;
                  z_r         <= (q_next == '0);
                  v_r         <= (a_r[MSB] == b_eff[MSB]) && (q_next[MSB] != a_r[MSB]);
               end
            end
            DONE: begin
               // Return to IDLE only; a new request waits for the next edge.
               if (out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign q         = q_r;
   assign c         = c_r;
   assign z         = z_r;
   assign v         = v_r;

endmodule : alu_serial_16

// File: tb/tb_alu_serial_16.sv
// tb/tb_alu_serial_16.sv - directed self-checking bench for alu_serial_16

module tb_alu_serial_16;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        s;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] q;
   logic        c;
   logic        z;
   logic        v;

   int n_checks;
   int n_fail;

   alu_serial_16 #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .s         (s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .c         (c),
      .z         (z),
      .v         (v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer one request and step past the accepting edge.
   task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic sv);
      a = av;
      b = bv;
      s = sv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count edges after acceptance until out_valid; stops at 20.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      s = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || q !== 16'h0 || c !== 1'b0 || z !== 1'b0 || v !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ov=%b q=%h c=%b z=%b v=%b, want all 0", out_valid, q, c, z, v);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_arith;
      // a, b, s, q, c, z, v
      logic [15:0] ta [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234};
      logic [15:0] tb [6] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h1234};
      logic        ts [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [15:0] eq [6] = '{16'h2233, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000};
      logic        ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic        ez [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic        ev [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      int lat;
      for (int i = 0; i < 6; i++) begin
         issue(ta[i], tb[i], ts[i]);
         wait_done(lat);
         n_checks++;
         if (lat !== 4) begin
            n_fail++;
            $display("FAIL arith_latency[%0d]: got %0d want 4", i, lat);
         end
         n_checks++;
         if (q !== eq[i] || c !== ec[i] || z !== ez[i] || v !== ev[i]) begin
            n_fail++;
            $display("FAIL arith_result[%0d]: got q=%h c=%b z=%b v=%b want q=%h c=%b z=%b v=%b",
                     i, q, c, z, v, eq[i], ec[i], ez[i], ev[i]);
         end
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         n_checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arith_handshake[%0d]: got ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure;
      int lat;
      issue(16'h1234, 16'h0FFF, 1'b1);
      wait_done(lat);
      a = 16'hFFFF;
      b = 16'h0001;
      s = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== 16'h2233 ||
             c !== 1'b0 || z !== 1'b0 || v !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got ov=%b ir=%b q=%h c=%b z=%b v=%b want ov=1 ir=0 q=2233 c=0 z=0 v=0",
                     k, out_valid, in_ready, q, c, z, v);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== 16'h2233) begin
         n_fail++;
         $display("FAIL bp_release: got ov=%b ir=%b q=%h want ov=0 ir=1 q=2233", out_valid, in_ready, q);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_idle_stays: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_abort;
      int lat;
      int seen;
      issue(16'h1234, 16'h1111, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || q !== 16'h0 || c !== 1'b0 || z !== 1'b0 || v !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_outputs: got ov=%b q=%h c=%b z=%b v=%b want all 0", out_valid, q, c, z, v);
      end
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if (seen !== 0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_no_valid: got valid_cycles=%0d ir=%b want 0 and ir=1", seen, in_ready);
      end
      issue(16'h0001, 16'h0001, 1'b1);
      wait_done(lat);
      n_checks++;
      if (lat !== 4 || q !== 16'h0002 || c !== 1'b0 || z !== 1'b0 || v !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_next_op: got lat=%0d q=%h c=%b z=%b v=%b want lat=4 q=0002 c=0 z=0 v=0",
                  lat, q, c, z, v);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [15:0] ta [3] = '{16'h0001, 16'h0010, 16'hAAAA};
      logic [15:0] tb [3] = '{16'h0002, 16'h0001, 16'h5555};
      logic        ts [3] = '{1'b1, 1'b0, 1'b1};
      logic [15:0] eq [3] = '{16'h0003, 16'h000F, 16'hFFFF};
      logic [15:0] res [3];
      int acc_cyc [3];
      int nacc;
      int nres;
      logic acc;
      logic hs;
      nacc = 0;
      nres = 0;
      a = ta[0];
      b = tb[0];
      s = ts[0];
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
         acc = in_valid && in_ready;
         hs  = out_valid && out_ready;
         if (hs) begin
            res[nres] = q;
            nres++;
         end
         @(posedge clk);
         #1;
         if (acc) begin
            acc_cyc[nacc] = cyc;
            nacc++;
            if (nacc < 3) begin
               a = ta[nacc];
               b = tb[nacc];
               s = ts[nacc];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (nacc !== 3 || nres !== 3) begin
         n_fail++;
         $display("FAIL b2b_counts: got accepts=%0d results=%0d want 3 and 3", nacc, nres);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (res[i] !== eq[i]) begin
               n_fail++;
               $display("FAIL b2b_result[%0d]: got %h want %h", i, res[i], eq[i]);
            end
         end
         for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
               n_fail++;
               $display("FAIL b2b_spacing[%0d]: got %0d want 6", i, acc_cyc[i] - acc_cyc[i-1]);
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      test_reset;
      test_arith;
      test_backpressure;
      test_reset_abort;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_alu_serial_16
